pf_stride_engine: RTL
=====================

Name: pf_stride_engine

Overview:
- Parametrised prefetch engine for the scmem hierarchy. Successor to the fixed 2/4-pipe prefetch front end.
- Accepts prefetch ops from the memory predictor. Each op carries a base, a signed stride, an element count and a target level (DC or L2).
- Queues ops and expands each one into a stream of line-aligned requests, one per cycle.
- Each request is steered to one of NPIPES cache pipes by line-address interleave. Keeps saturating issue and drop statistics.

Parameters:
NPIPES, 2, number of cache pipes per level (1, 2 or 4)
ADDR_W, 48, byte address width
STRIDE_W, 16, signed stride width in bytes
CNT_W, 4, element count width
LINE_BITS, 6, log2 of cache line size in bytes
QDEPTH, 4, op queue depth (power of 2, at least 2)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
flush  in  1  synchronous: drop queued and in-flight ops
op_valid  in  1  op offered
op_retry  out  1  op not accepted this cycle
op_addr  in  ADDR_W  base byte address
op_stride  in  STRIDE_W  signed byte stride
op_count  in  CNT_W  number of elements (0 = null op)
op_l2  in  1  1 = target L2, 0 = target DC
dc_req_valid  out  NPIPES  per-pipe DC request valid
dc_req_retry  in  NPIPES  per-pipe DC back-pressure
dc_req_addr  out  NPIPES*ADDR_W  per-pipe line-aligned address; pipe p occupies bits [p*ADDR_W +: ADDR_W]
l2_req_valid  out  NPIPES  per-pipe L2 request valid
l2_req_retry  in  NPIPES  per-pipe L2 back-pressure
l2_req_addr  out  NPIPES*ADDR_W  per-pipe line-aligned address
stat_issued_dc  out  16  DC requests accepted, saturating
stat_issued_l2  out  16  L2 requests accepted, saturating
stat_merged  out  16  elements suppressed as same-line duplicates, saturating
stat_dropped  out  16  null ops plus ops lost to flush, saturating
busy  out  1  queue non-empty or generator not IDLE

Behaviour:
- Handshake: a transfer occurs in any cycle where valid=1 and retry=0.
- Input side: op_retry = queue_full OR flush OR reset. This is combinational.
- Output side: a request held under retry keeps its address and valid stable until it is accepted or flushed.
- Reset values: all *_req_valid=0; all *_req_addr=0; stats=0; queue empty; FSM=IDLE; busy=0; op_retry=1 while reset is high and 0 in the first cycle after.
- FSM has two states, IDLE and ISSUE.
- IDLE, queue non-empty: pop the head.
  - count=0: stat_dropped+1 and stay in IDLE.
  - count>0: load cur=addr, rem=count, last_line=invalid; go to ISSUE.
- ISSUE, per element:
  - line = cur[ADDR_W-1:LINE_BITS].
  - pipe = line[log2(NPIPES)-1:0]; pipe = 0 when NPIPES=1.
  - Output address = {line, LINE_BITS zeros}.
  - Only the selected pipe at the selected level drives valid=1.
- Duplicate merge: if line equals last_line, the element is consumed in one cycle with no valid asserted, and stat_merged+1.
- Advance: on transfer or merge, set cur = cur + sext(stride), wrapping modulo 2^ADDR_W; rem-1; last_line = line. When rem reaches 0, go to IDLE.
- Latency:
  - Op accepted in cycle T into an idle, empty engine: first request valid in T+2.
  - Requests within one op are back-to-back: one per cycle when there is no retry.
  - Last transfer of an op in cycle C, next op queued: the next op's first valid appears in C+2 (one IDLE bubble).
- Queue: FIFO of QDEPTH entries.
  - Push and pop in the same cycle are allowed.
  - When full, op_retry=1 and the offered op is not captured.
- flush (takes priority over everything except reset):
  - In the flush cycle: the queue is cleared and FSM goes to IDLE. stat_dropped increases by (queue occupancy + 1 if FSM was ISSUE).
  - From the next cycle: all req_valid=0. The op offered in the flush cycle is not accepted.
  - A request presented in the flush cycle counts as issued only if it transferred in that cycle.
- Stats: each counter adds at most one per event per cycle and saturates at 16'hFFFF. When flush and a pop of a null op land in the same cycle, the sum is applied once.
- Reset mid-op: all state returns to reset values in the following cycle. No partial stream resumes.

Test Plan:
- NPIPES=2: op addr=0x1000, stride=64, count=4, DC, no retry -> dc valid on pipes 0,1,0,1 at T+2..T+5 with addrs 0x1000, 0x1040, 0x1080, 0x10C0; stat_issued_dc=4; busy drops in T+6.
- Op stride=16, count=8, L2, addr 0x2000 -> 2 L2 requests (0x2000, 0x2040); stat_merged=6.
- Op stride=-64, count=3, addr 0x40 -> addrs 0x40, 0x0, then 0xFFFF_FFFF_FFC0 (48-bit wrap).
- Hold dc_req_retry[1]=1 for 5 cycles on a pipe-1 request -> address and valid stable throughout; accepted on the release cycle; the next request follows in the next cycle.
- Offer QDEPTH+2 ops back-to-back while the first op stalls under retry -> op_retry=1 once the queue is full; no op lost or duplicated; count=0 op -> stat_dropped+1 and no request issued.
- Flush while issuing with 2 ops queued -> all valids 0 the next cycle; stat_dropped+3; an op offered in the same cycle is rejected; reset mid-stream clears all outputs to 0.

Source files
------------

// File: rtl/pf_stride_engine.sv
// Strided prefetch engine: queues prefetch ops and expands each into a stream of
// line-aligned requests, steered across NPIPES cache pipes per level by line interleave.
module pf_stride_engine #(
    parameter int NPIPES    = 2,
    parameter int ADDR_W    = 48,
    parameter int STRIDE_W  = 16,
    parameter int CNT_W     = 4,
    parameter int LINE_BITS = 6,
    parameter int QDEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    // Every channel transfers in a cycle where valid=1 and retry=0; a held request keeps valid and address stable.
    input  logic                     op_valid,
    output logic                     op_retry,
    input  logic [ADDR_W-1:0]        op_addr,
    input  logic [STRIDE_W-1:0]      op_stride,
    input  logic [CNT_W-1:0]         op_count,
    input  logic                     op_l2,
    output logic [NPIPES-1:0]        dc_req_valid,
    input  logic [NPIPES-1:0]        dc_req_retry,
    output logic [NPIPES*ADDR_W-1:0] dc_req_addr,
    output logic [NPIPES-1:0]        l2_req_valid,
    input  logic [NPIPES-1:0]        l2_req_retry,
    output logic [NPIPES*ADDR_W-1:0] l2_req_addr,
    output logic [15:0]              stat_issued_dc,
    output logic [15:0]              stat_issued_l2,
    output logic [15:0]              stat_merged,
    output logic [15:0]              stat_dropped,
    output logic                     busy,
    output logic                     dbg_state
);

    localparam int LINE_W = ADDR_W - LINE_BITS;
    localparam int SEL_W  = (NPIPES > 1) ? $clog2(NPIPES) : 1;
    localparam int PTR_W  = $clog2(QDEPTH);
    localparam int OCC_W  = PTR_W + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Op queue storage and pointers.
    logic [ADDR_W-1:0]   q_addr_q   [QDEPTH];
    logic [STRIDE_W-1:0] q_stride_q [QDEPTH];
    logic [CNT_W-1:0]    q_count_q  [QDEPTH];
    logic [QDEPTH-1:0]   q_l2_q;
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [OCC_W-1:0]    occ_q;
    logic                q_empty;
    logic                q_full;
    logic                push;
    logic                pop;
    logic                null_pop;

    // Generator state.
    state_t              state_q;
    logic [ADDR_W-1:0]   cur_q;
    logic [STRIDE_W-1:0] stride_q;
    logic [CNT_W-1:0]    rem_q;
    logic                l2_q;
    logic [LINE_W-1:0]   last_line_q;
    logic                last_vld_q;

    logic [LINE_W-1:0]   cur_line;
    logic [ADDR_W-1:0]   req_line_addr;
    logic [ADDR_W-1:0]   stride_ext;
    logic [SEL_W-1:0]    pipe_sel;
    logic                dup;
    logic                issue_vld;
    logic                fire;
    logic                advance;
    logic                merge_ev;

    logic [15:0]         stat_issued_dc_q;
    logic [15:0]         stat_issued_l2_q;
    logic [15:0]         stat_merged_q;
    logic [15:0]         stat_dropped_q;
    logic [15:0]         drop_inc;

    assign q_empty  = (occ_q == '0);
    assign q_full   = (occ_q == OCC_W'(QDEPTH));
    assign op_retry = q_full | flush | reset;
    assign push     = op_valid & ~op_retry;
    assign pop      = (state_q == IDLE) & ~q_empty & ~flush & ~reset;
    assign null_pop = pop & (q_count_q[rd_ptr_q] == '0);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Payload storage needs no reset; occupancy alone says what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr_q[wr_ptr_q]   <= op_addr;
            q_stride_q[wr_ptr_q] <= op_stride;
            q_count_q[wr_ptr_q]  <= op_count;
            q_l2_q[wr_ptr_q]     <= op_l2;
        end
    end

    assign cur_line      = cur_q[ADDR_W-1:LINE_BITS];
    assign req_line_addr = {cur_line, {LINE_BITS{1'b0}}};
    assign stride_ext    = {{(ADDR_W-STRIDE_W){stride_q[STRIDE_W-1]}}, stride_q};
    assign pipe_sel      = (NPIPES > 1) ? cur_line[SEL_W-1:0] : '0;
    assign dup           = last_vld_q & (cur_line == last_line_q);
    assign issue_vld     = (state_q == ISSUE) & ~dup;
    assign merge_ev      = (state_q == ISSUE) & dup & ~flush;

    always_comb begin
        dc_req_valid = '0;
        l2_req_valid = '0;
        dc_req_addr  = '0;
        l2_req_addr  = '0;
        for (int p = 0; p < NPIPES; p++) begin
            if (issue_vld && (pipe_sel == SEL_W'(p))) begin
                if (l2_q) begin
                    l2_req_valid[p]                  = 1'b1;
                    l2_req_addr[p*ADDR_W +: ADDR_W] = req_line_addr;
                end else begin
                    dc_req_valid[p]                  = 1'b1;
                    dc_req_addr[p*ADDR_W +: ADDR_W] = req_line_addr;
                end
            end
        end
    end

    assign fire    = issue_vld & ~(|(dc_req_valid & dc_req_retry)) & ~(|(l2_req_valid & l2_req_retry));
    assign advance = (state_q == ISSUE) & (fire | dup);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            stride_q    <= '0;
            rem_q       <= '0;
            l2_q        <= 1'b0;
            last_line_q <= '0;
            last_vld_q  <= 1'b0;
        end else if (flush) begin
            state_q    <= IDLE;
            last_vld_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop && !null_pop) begin
                        cur_q      <= q_addr_q[rd_ptr_q];
                        stride_q   <= q_stride_q[rd_ptr_q];
                        rem_q      <= q_count_q[rd_ptr_q];
                        l2_q       <= q_l2_q[rd_ptr_q];
                        last_vld_q <= 1'b0;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (advance) begin
                        cur_q       <= cur_q + stride_ext;
                        rem_q       <= rem_q - CNT_W'(1);
                        last_line_q <= cur_line;
                        last_vld_q  <= 1'b1;
                        if (rem_q == CNT_W'(1)) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A flush drops everything queued plus the op being expanded; pop is blocked then, so no double count.
    assign drop_inc = flush ? (16'(occ_q) + 16'(state_q == ISSUE)) : 16'(null_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_issued_dc_q <= '0;
            stat_issued_l2_q <= '0;
            stat_merged_q    <= '0;
            stat_dropped_q   <= '0;
        end else begin
            stat_issued_dc_q <= sat_add(stat_issued_dc_q, 16'(fire & ~l2_q));
            stat_issued_l2_q <= sat_add(stat_issued_l2_q, 16'(fire & l2_q));
            stat_merged_q    <= sat_add(stat_merged_q, 16'(merge_ev));
            stat_dropped_q   <= sat_add(stat_dropped_q, drop_inc);
        end
    end

    assign stat_issued_dc = stat_issued_dc_q;
    assign stat_issued_l2 = stat_issued_l2_q;
    assign stat_merged    = stat_merged_q;
    assign stat_dropped   = stat_dropped_q;
    assign busy           = ~q_empty | (state_q == ISSUE);
    assign dbg_state      = state_q;

endmodule
